// File: rtl/fetch_debug_ctrl.sv
// Debug sequencer owning instruction fetch: loads program words byte-by-byte into imem
// and gates pc_we/if_id_we for free-run and single-step execution. All outputs registered.
module fetch_debug_ctrl #(
    parameter int NB_BITS   = 32,
    parameter int NB_BYTE   = 8,
    parameter int MEM_DEPTH = 32,
    parameter int NB_CNT    = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NB_BYTE-1:0]           i_rx_data,
    input  logic                         i_rx_valid,
    output logic                         o_rx_ready,
    input  logic [1:0]                   i_cmd,
    input  logic                         i_cmd_valid,
    input  logic                         i_halt,
    output logic [NB_BITS-1:0]           o_mem_addr,
    output logic [NB_BITS-1:0]           o_mem_wdata,
    output logic                         o_mem_we,
    output logic                         o_fetch_en,
    output logic [$clog2(MEM_DEPTH):0]   o_loaded_words,
    output logic [NB_CNT-1:0]            o_cycle_count,
    output logic [2:0]                   o_state
);
    localparam int LANES    = NB_BITS / NB_BYTE;
    localparam int NB_LANE  = $clog2(LANES);
    localparam int NB_IDX   = $clog2(MEM_DEPTH);
    localparam int NB_WORDS = NB_IDX + 1;

    localparam logic [1:0] CMD_ABORT = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_RUN   = 2'b10;
    localparam logic [1:0] CMD_STEP  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t               state;
    logic [NB_LANE-1:0]   byte_cnt;
    logic [NB_IDX-1:0]    word_idx;
    logic [NB_BITS-1:0]   word_buf;
    logic                 last_word;
    logic [NB_BITS-1:0]   next_word;
    logic                 rx_fire;
    logic                 abort;

    assign rx_fire = i_rx_valid & o_rx_ready;
    assign abort   = i_cmd_valid & (i_cmd == CMD_ABORT);
    assign o_state = state;

    // Word with the incoming byte dropped into its little-endian lane.
    always_comb begin
        next_word = word_buf;
        next_word[int'(byte_cnt) * NB_BYTE +: NB_BYTE] = i_rx_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            o_rx_ready     <= 1'b0;
            o_mem_we       <= 1'b0;
            o_fetch_en     <= 1'b0;
            o_mem_addr     <= '0;
            o_mem_wdata    <= '0;
            o_loaded_words <= '0;
            o_cycle_count  <= '0;
            byte_cnt       <= '0;
            word_idx       <= '0;
            word_buf       <= '0;
            last_word      <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            if (o_fetch_en && !(&o_cycle_count))
                o_cycle_count <= o_cycle_count + NB_CNT'(1);

            if (abort) begin
                state      <= ST_IDLE;
                o_fetch_en <= 1'b0;
                o_rx_ready <= 1'b0;
                byte_cnt   <= '0;
                last_word  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (i_cmd_valid) begin
                            case (i_cmd)
                                CMD_LOAD: begin
                                    state          <= ST_LOAD;
                                    o_rx_ready     <= 1'b1;
                                    o_loaded_words <= '0;
                                    o_cycle_count  <= '0;
                                    byte_cnt       <= '0;
                                    word_idx       <= '0;
                                    last_word      <= 1'b0;
                                end
                                CMD_RUN: begin
                                    state      <= ST_RUN;
                                    o_fetch_en <= 1'b1;
                                end
                                CMD_STEP: begin
                                    state      <= ST_STEP;
                                    o_fetch_en <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_LOAD: begin
                        // The final word's strobe cycle closes the load; bytes offered then are dropped.
                        if (o_mem_we && last_word) begin
                            state      <= ST_IDLE;
                            o_rx_ready <= 1'b0;
                            byte_cnt   <= '0;
                            last_word  <= 1'b0;
                        end else if (rx_fire) begin
                            word_buf <= next_word;
                            byte_cnt <= byte_cnt + NB_LANE'(1);
                            if (byte_cnt == NB_LANE'(LANES - 1)) begin
                                o_mem_we       <= 1'b1;
                                o_mem_wdata    <= next_word;
                                o_mem_addr     <= NB_BITS'({word_idx, 2'b00});
                                word_idx       <= word_idx + NB_IDX'(1);
                                o_loaded_words <= o_loaded_words + NB_WORDS'(1);
                                last_word      <= (&next_word) ||
                                                  (word_idx == NB_IDX'(MEM_DEPTH - 1));
                            end
                        end
                    end
                    ST_RUN: begin
                        if (i_halt) begin
                            o_fetch_en <= 1'b0;
                            state      <= ST_DONE;
                        end
                    end
                    ST_STEP: begin
                        o_fetch_en <= 1'b0;
                        state      <= i_halt ? ST_DONE : ST_IDLE;
                    end
                    default: begin
                        state      <= ST_IDLE;
                        o_fetch_en <= 1'b0;
                        o_rx_ready <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_debug_ctrl.sv
// Directed bench for fetch_debug_ctrl: vector table plus multi-cycle sequences.
module tb_fetch_debug_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [1:0]  cmd = '0;
    logic        cmd_valid = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        fetch_en;
    logic [5:0]  loaded_words;
    logic [31:0] cycle_count;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] A = 2'b00, L = 2'b01, R = 2'b10, S = 2'b11;

    fetch_debug_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
        .i_cmd(cmd), .i_cmd_valid(cmd_valid), .i_halt(halt),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
        .o_fetch_en(fetch_en), .o_loaded_words(loaded_words),
        .o_cycle_count(cycle_count), .o_state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, cv;
        logic [1:0]  cmd;
        logic        rv;
        logic [7:0]  rd;
        logic        halt;
        logic [2:0]  st;
        logic        rdy, we, fe;
        logic [31:0] addr, wdata;
        logic [5:0]  lw;
        logic [31:0] cc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic cv, input logic [1:0] c,
                                input logic rv, input logic [7:0] rd, input logic h,
                                input logic [2:0] st, input logic rdy, input logic we,
                                input logic fe, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [5:0] lw,
                                input logic [31:0] cc);
        vec_t v;
        v.rst = r; v.cv = cv; v.cmd = c; v.rv = rv; v.rd = rd; v.halt = h;
        v.st = st; v.rdy = rdy; v.we = we; v.fe = fe; v.addr = addr;
        v.wdata = wdata; v.lw = lw; v.cc = cc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_pulse(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    vec_t vecs[31];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int n;
        int strobes;
        logic [31:0] last_addr;

        vecs[0]  = mk(1,0,A,0,8'h00,0, 0,0,0,0, 32'h0, 32'h0,        0, 0);
        vecs[1]  = mk(0,1,L,0,8'h00,0, 1,1,0,0, 32'h0, 32'h0,        0, 0);
        vecs[2]  = mk(0,0,A,1,8'h13,0, 1,1,0,0, 32'h0, 32'h0,        0, 0);
        vecs[3]  = mk(0,0,A,1,8'h00,0, 1,1,0,0, 32'h0, 32'h0,        0, 0);
        vecs[4]  = mk(0,0,A,1,8'h40,0, 1,1,0,0, 32'h0, 32'h0,        0, 0);
        vecs[5]  = mk(0,0,A,1,8'h20,0, 1,1,1,0, 32'h0, 32'h20400013, 1, 0);
        vecs[6]  = mk(0,0,A,0,8'h00,0, 1,1,0,0, 32'h0, 32'h20400013, 1, 0);
        vecs[7]  = mk(0,0,A,1,8'h78,0, 1,1,0,0, 32'h0, 32'h20400013, 1, 0);
        vecs[8]  = mk(0,0,A,1,8'h56,0, 1,1,0,0, 32'h0, 32'h20400013, 1, 0);
        vecs[9]  = mk(0,0,A,1,8'h34,0, 1,1,0,0, 32'h0, 32'h20400013, 1, 0);
        vecs[10] = mk(0,0,A,1,8'h12,0, 1,1,1,0, 32'h4, 32'h12345678, 2, 0);
        vecs[11] = mk(0,0,A,1,8'hFF,0, 1,1,0,0, 32'h4, 32'h12345678, 2, 0);
        vecs[12] = mk(0,0,A,1,8'hFF,0, 1,1,0,0, 32'h4, 32'h12345678, 2, 0);
        vecs[13] = mk(0,0,A,1,8'hFF,0, 1,1,0,0, 32'h4, 32'h12345678, 2, 0);
        vecs[14] = mk(0,0,A,1,8'hFF,0, 1,1,1,0, 32'h8, 32'hFFFFFFFF, 3, 0);
        vecs[15] = mk(0,0,A,0,8'h00,0, 0,0,0,0, 32'h8, 32'hFFFFFFFF, 3, 0);
        vecs[16] = mk(0,0,A,1,8'hAB,0, 0,0,0,0, 32'h8, 32'hFFFFFFFF, 3, 0);
        vecs[17] = mk(0,1,S,0,8'h00,0, 3,0,0,1, 32'h8, 32'hFFFFFFFF, 3, 0);
        vecs[18] = mk(0,0,A,0,8'h00,0, 0,0,0,0, 32'h8, 32'hFFFFFFFF, 3, 1);
        vecs[19] = mk(0,0,A,0,8'h00,0, 0,0,0,0, 32'h8, 32'hFFFFFFFF, 3, 1);
        vecs[20] = mk(0,1,S,0,8'h00,0, 3,0,0,1, 32'h8, 32'hFFFFFFFF, 3, 1);
        vecs[21] = mk(0,0,A,0,8'h00,0, 0,0,0,0, 32'h8, 32'hFFFFFFFF, 3, 2);
        vecs[22] = mk(0,1,S,0,8'h00,0, 3,0,0,1, 32'h8, 32'hFFFFFFFF, 3, 2);
        vecs[23] = mk(0,0,A,0,8'h00,1, 4,0,0,0, 32'h8, 32'hFFFFFFFF, 3, 3);
        vecs[24] = mk(0,1,L,0,8'h00,0, 1,1,0,0, 32'h8, 32'hFFFFFFFF, 0, 0);
        vecs[25] = mk(0,1,A,0,8'h00,1, 0,0,0,0, 32'h8, 32'hFFFFFFFF, 0, 0);
        vecs[26] = mk(0,1,R,0,8'h00,0, 2,0,0,1, 32'h8, 32'hFFFFFFFF, 0, 0);
        vecs[27] = mk(0,1,A,0,8'h00,1, 0,0,0,0, 32'h8, 32'hFFFFFFFF, 0, 1);
        vecs[28] = mk(0,1,R,0,8'h00,0, 2,0,0,1, 32'h8, 32'hFFFFFFFF, 0, 1);
        vecs[29] = mk(0,1,L,0,8'h00,0, 2,0,0,1, 32'h8, 32'hFFFFFFFF, 0, 2);
        vecs[30] = mk(0,0,A,0,8'h00,1, 4,0,0,0, 32'h8, 32'hFFFFFFFF, 0, 3);

        for (int i = 0; i < 31; i++) begin
            rst = vecs[i].rst; cmd_valid = vecs[i].cv; cmd = vecs[i].cmd;
            rx_valid = vecs[i].rv; rx_data = vecs[i].rd; halt = vecs[i].halt;
            tick();
            check($sformatf("v%0d.state", i), 64'(state),        64'(vecs[i].st));
            check($sformatf("v%0d.rdy", i),   64'(rx_ready),     64'(vecs[i].rdy));
            check($sformatf("v%0d.we", i),    64'(mem_we),       64'(vecs[i].we));
            check($sformatf("v%0d.fe", i),    64'(fetch_en),     64'(vecs[i].fe));
            check($sformatf("v%0d.addr", i),  64'(mem_addr),     64'(vecs[i].addr));
            check($sformatf("v%0d.wdata", i), 64'(mem_wdata),    64'(vecs[i].wdata));
            check($sformatf("v%0d.lw", i),    64'(loaded_words), 64'(vecs[i].lw));
            check($sformatf("v%0d.cc", i),    64'(cycle_count),  64'(vecs[i].cc));
        end
        rst = 1'b0; cmd_valid = 1'b0; rx_valid = 1'b0; halt = 1'b0;

        // RUN for exactly 10 enabled cycles, halt in the 10th.
        cmd_pulse(L);
        cmd_pulse(A);
        check("run.cc_cleared", 64'(cycle_count), 64'd0);
        cmd_pulse(R);
        n = 0;
        while (fetch_en === 1'b1 && n < 50) begin
            n++;
            halt = (n == 10);
            tick();
        end
        halt = 1'b0;
        check("run.enabled_cycles", 64'(n), 64'd10);
        check("run.fe_after_halt", 64'(fetch_en), 64'd0);
        check("run.cycle_count", 64'(cycle_count), 64'd10);
        check("run.state_done", 64'(state), 64'd4);
        cmd_pulse(R);
        check("run.rerun_state", 64'(state), 64'd2);
        check("run.rerun_fe", 64'(fetch_en), 64'd1);
        cmd_pulse(A);
        check("run.abort_state", 64'(state), 64'd0);
        check("run.abort_fe", 64'(fetch_en), 64'd0);

        // Reset in the middle of a word, then a fresh load from address 0.
        cmd_pulse(L);
        rx_valid = 1'b1; rx_data = 8'h11; tick();
        rx_data = 8'h22; tick();
        rx_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst.state", 64'(state), 64'd0);
        check("rst.rdy", 64'(rx_ready), 64'd0);
        check("rst.we", 64'(mem_we), 64'd0);
        check("rst.fe", 64'(fetch_en), 64'd0);
        check("rst.addr", 64'(mem_addr), 64'd0);
        check("rst.wdata", 64'(mem_wdata), 64'd0);
        check("rst.lw", 64'(loaded_words), 64'd0);
        check("rst.cc", 64'(cycle_count), 64'd0);
        cmd_pulse(L);
        rx_valid = 1'b1;
        rx_data = 8'h44; tick();
        rx_data = 8'h33; tick();
        rx_data = 8'h22; tick();
        rx_data = 8'h11; tick();
        rx_valid = 1'b0;
        check("rst.reload_we", 64'(mem_we), 64'd1);
        check("rst.reload_addr", 64'(mem_addr), 64'd0);
        check("rst.reload_wdata", 64'(mem_wdata), 64'h11223344);
        check("rst.reload_lw", 64'(loaded_words), 64'd1);
        cmd_pulse(A);

        // Full-depth load with back-to-back bytes and no halt marker.
        cmd_pulse(L);
        strobes = 0;
        last_addr = '0;
        for (int i = 0; i < 128; i++) begin
            rx_valid = 1'b1;
            rx_data = (i % 4 == 0) ? 8'(i / 4) : 8'h00;
            tick();
            if (mem_we === 1'b1) begin
                check($sformatf("full.addr%0d", strobes), 64'(mem_addr), 64'(strobes * 4));
                check($sformatf("full.wdata%0d", strobes), 64'(mem_wdata), 64'(strobes));
                strobes++;
                last_addr = mem_addr;
            end
        end
        rx_valid = 1'b0;
        check("full.strobes", 64'(strobes), 64'd32);
        check("full.last_addr", 64'(last_addr), 64'h7C);
        tick();
        check("full.state_idle", 64'(state), 64'd0);
        check("full.rdy_low", 64'(rx_ready), 64'd0);
        check("full.lw", 64'(loaded_words), 64'd32);
        rx_valid = 1'b1; rx_data = 8'hAA;
        tick();
        rx_valid = 1'b0;
        check("full.extra_rdy", 64'(rx_ready), 64'd0);
        check("full.extra_we", 64'(mem_we), 64'd0);
        check("full.extra_lw", 64'(loaded_words), 64'd32);
        check("full.extra_state", 64'(state), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
